// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch requester, data requester and mem_system port signals
// that surround mem_arbiter.
//   slave  : the arbiter's view (accepts requests, drives the cache port)
//   master : the surrounding pipeline / mem_system view
interface mem_arbiter_if;
   // fetch requester
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_done;
   logic [15:0] i_data;
   logic        i_hit;
   // data requester
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_done;
   logic [15:0] d_data;
   logic        d_hit;
   // shared mem_system port
   logic [15:0] m_addr;
   logic [15:0] m_wdata;
   logic        m_rd;
   logic        m_wr;
   logic [15:0] m_rdata;
   logic        m_done;
   logic        m_hit;
   logic        m_err;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
      input  m_rdata, m_done, m_hit, m_err,
      output i_done, i_data, i_hit, d_done, d_data, d_hit,
      output m_addr, m_wdata, m_rd, m_wr
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
      output m_rdata, m_done, m_hit, m_err,
      input  i_done, i_data, i_hit, d_done, d_data, d_hit,
      input  m_addr, m_wdata, m_rd, m_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one mem_system port between the instruction-fetch requester (read
// only) and the data requester (read/write). The winning request is latched,
// Rd/Wr are held until the cache reports Done, and the result is returned to
// the winner with a one-cycle done pulse. A watchdog aborts a transaction
// that waits TIMEOUT cycles without Done; aborts and cache errors set a
// sticky err flag.
//
// Configuration macro MEM_ARB_RR_EN:
//   defined   - round-robin on a tie (port opposite last_gnt wins)
//   undefined - fixed priority, data port wins a tie
//
// TIMEOUT: 1..255 (8-bit watchdog counter).
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         busy,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

   state_t      state_r;
   logic        busy_r;
   logic        gnt_r;        // 0 = fetch, 1 = data
   logic        last_gnt_r;
   logic        wr_r;
   logic [15:0] addr_r;       // zero outside WAIT
   logic [15:0] wdata_r;      // zero outside WAIT
   logic [7:0]  cnt_r;
   logic        err_r;

   logic        i_done_r;
   logic [15:0] i_data_r;
   logic        i_hit_r;
   logic        d_done_r;
   logic [15:0] d_data_r;
   logic        d_hit_r;

   logic        pick_d_s;
   logic        wait_s;
   logic [7:0]  cnt_inc_s;
   logic        timeout_s;
   logic        finish_s;
   logic        abort_s;
   logic [15:0] resp_data_s;
   logic        resp_hit_s;

   assign wait_s    = (state_r == WAIT);
   assign cnt_inc_s = cnt_r + 8'd1;
   // The count reaches TIMEOUT at the end of the TIMEOUT-th WAIT cycle.
   assign timeout_s = (cnt_inc_s == TIMEOUT_C);
   // m_done in the last allowed WAIT cycle still wins over the abort.
   assign finish_s  = bus.m_done | timeout_s;
   assign abort_s   = wait_s & ~bus.m_done & timeout_s;

   // Select the winning port for a request seen in IDLE.
   always_comb begin
      pick_d_s = 1'b0;
      if (bus.i_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
         pick_d_s = ~last_gnt_r;
`else
         // Fixed priority: data always wins; last_gnt does not affect the outcome.
         pick_d_s = last_gnt_r | 1'b1;
`endif
      end else if (bus.d_req) begin
         pick_d_s = 1'b1;
      end else begin
         pick_d_s = 1'b0;
      end
   end

   // Response value: cache data on Done, zero on a watchdog abort.
   always_comb begin
      resp_data_s = 16'h0000;
      resp_hit_s  = 1'b0;
      if (bus.m_done) begin
         resp_data_s = bus.m_rdata;
         resp_hit_s  = bus.m_hit;
      end else begin
         resp_data_s = 16'h0000;
         resp_hit_s  = 1'b0;
      end
   end

   // Arbiter state machine: grant in IDLE, wait on the cache, pulse done in RESP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         busy_r     <= 1'b0;
         gnt_r      <= 1'b0;
         last_gnt_r <= 1'b1;
         wr_r       <= 1'b0;
         addr_r     <= 16'h0000;
         wdata_r    <= 16'h0000;
         cnt_r      <= 8'd0;
         i_done_r   <= 1'b0;
         i_data_r   <= 16'h0000;
         i_hit_r    <= 1'b0;
         d_done_r   <= 1'b0;
         d_data_r   <= 16'h0000;
         d_hit_r    <= 1'b0;
      end else begin
         // Done pulses and their data last exactly one cycle.
         i_done_r <= 1'b0;
         i_data_r <= 16'h0000;
         i_hit_r  <= 1'b0;
         d_done_r <= 1'b0;
         d_data_r <= 16'h0000;
         d_hit_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  gnt_r   <= pick_d_s;
                  wr_r    <= pick_d_s & bus.d_wr;
                  addr_r  <= pick_d_s ? bus.d_addr : bus.i_addr;
                  wdata_r <= pick_d_s ? bus.d_wdata : 16'h0000;
                  cnt_r   <= 8'd0;
                  busy_r  <= 1'b1;
                  state_r <= WAIT;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            WAIT: begin
               if (finish_s) begin
                  if (gnt_r) begin
                     d_done_r <= 1'b1;
                     d_data_r <= resp_data_s;
                     d_hit_r  <= resp_hit_s;
                  end else begin
                     i_done_r <= 1'b1;
                     i_data_r <= resp_data_s;
                     i_hit_r  <= resp_hit_s;
                  end
                  wr_r    <= 1'b0;
                  addr_r  <= 16'h0000;
                  wdata_r <= 16'h0000;
                  state_r <= RESP;
               end else begin
                  cnt_r   <= cnt_inc_s;
                  state_r <= WAIT;
               end
            end
            RESP: begin
               last_gnt_r <= gnt_r;
               busy_r     <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               wr_r    <= 1'b0;
               addr_r  <= 16'h0000;
               wdata_r <= 16'h0000;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Sticky error: any cache error or a watchdog abort, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_r <= 1'b0;
      end else if (bus.m_err || abort_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Rd/Wr drop in the Done cycle so mem_system returns to idle instead of re-issuing.
   assign bus.m_rd    = wait_s & ~wr_r & ~bus.m_done;
   assign bus.m_wr    = wait_s &  wr_r & ~bus.m_done;
   assign bus.m_addr  = addr_r;
   assign bus.m_wdata = wdata_r;

   assign bus.i_done  = i_done_r;
   assign bus.i_data  = i_data_r;
   assign bus.i_hit   = i_hit_r;
   assign bus.d_done  = d_done_r;
   assign bus.d_data  = d_data_r;
   assign bus.d_hit   = d_hit_r;

   assign busy = busy_r;
   assign err  = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Table of directed transactions, hand sequences for reset/tie corners, and a
// randomized phase checked against a transaction-level reference model. The
// bench plays both requesters and a behavioural mem_system.
module tb_mem_arbiter;
   localparam int TO = 24;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic err;

   mem_arbiter_if bus_if();

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus_if),
      .busy (busy),
      .err  (err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        pre_rst;
      logic        ir;
      logic        dr;
      logic        dw;
      logic [15:0] ia;
      logic [15:0] da;
      logic [15:0] dwd;
      int          lat;      // WAIT cycle in which the cache answers
      logic [15:0] rdat;
      logic        hit;
      int          merr;     // WAIT cycle with an m_err pulse, 0 = none
      logic        exp_port;
      int          exp_k;    // cycle of the done pulse, grant cycle = 0
      logic [15:0] exp_data;
      logic        exp_hit;
      logic        exp_err;
   } vec_t;

   vec_t tbl [9];

   logic [15:0] mem [logic [15:0]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus_if.i_req   = 1'b0;
      bus_if.i_addr  = 16'h0000;
      bus_if.d_req   = 1'b0;
      bus_if.d_wr    = 1'b0;
      bus_if.d_addr  = 16'h0000;
      bus_if.d_wdata = 16'h0000;
      bus_if.m_rdata = 16'h0000;
      bus_if.m_done  = 1'b0;
      bus_if.m_hit   = 1'b0;
      bus_if.m_err   = 1'b0;
   endtask

   task automatic reset_dut();
      step();
      rst = 1'b0;
      drive_idle();
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      #2;
      chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
      chk({tag, "_err"}, 32'(err), 32'(1'b0));
      chk({tag, "_mrdwr"}, 32'({bus_if.m_rd, bus_if.m_wr}), 32'(2'b00));
      chk({tag, "_maddr"}, 32'({bus_if.m_addr, bus_if.m_wdata}), 32'd0);
      chk({tag, "_dones"}, 32'({bus_if.i_done, bus_if.d_done, bus_if.i_hit, bus_if.d_hit}), 32'd0);
      chk({tag, "_data"}, {bus_if.i_data, bus_if.d_data}, 32'd0);
   endtask

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      else return a ^ 16'h5A5A;
   endfunction

   // One transaction: request in cycle 0 (IDLE), cache answers in WAIT cycle
   // lat, per-cycle checks of the cache port up to WAIT cycle eend, then the
   // first done pulse is reported back.
   task automatic txn(input logic ir, input logic dr, input logic dw,
                      input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dwd,
                      input int lat, input logic [15:0] rdat, input logic hit, input int merr_k,
                      input logic ewr, input logic [15:0] eaddr, input logic [15:0] ewdata,
                      input int eend,
                      output int done_k, output logic dport, output logic [15:0] odata,
                      output logic ohit, output logic oerr);
      done_k = -1;
      dport  = 1'b0;
      odata  = 16'h0000;
      ohit   = 1'b0;
      oerr   = 1'b0;
      step();
      bus_if.i_req   = ir;
      bus_if.i_addr  = ia;
      bus_if.d_req   = dr;
      bus_if.d_wr    = dw;
      bus_if.d_addr  = da;
      bus_if.d_wdata = dwd;
      bus_if.m_done  = 1'b0;
      bus_if.m_err   = 1'b0;
      #2;
      chk("idle_busy", 32'(busy), 32'(1'b0));
      chk("idle_mrdwr", 32'({bus_if.m_rd, bus_if.m_wr}), 32'(2'b00));
      for (int k = 1; k <= eend + 4; k++) begin
         step();
         bus_if.m_done  = (k == lat) && (k <= eend);
         bus_if.m_rdata = (k == lat) ? rdat : 16'($urandom);
         bus_if.m_hit   = (k == lat) ? hit : 1'($urandom);
         bus_if.m_err   = (k == merr_k) && (k <= eend);
         #2;
         if (k <= eend) begin
            chk("wait_busy", 32'(busy), 32'(1'b1));
            chk("wait_m_rd", 32'(bus_if.m_rd), 32'(!ewr && (k != lat)));
            chk("wait_m_wr", 32'(bus_if.m_wr), 32'(ewr && (k != lat)));
            chk("wait_m_addr", 32'(bus_if.m_addr), 32'(eaddr));
            if (ewr) chk("wait_m_wdata", 32'(bus_if.m_wdata), 32'(ewdata));
         end
         if (bus_if.i_done || bus_if.d_done) begin
            done_k = k;
            dport  = bus_if.d_done;
            odata  = dport ? bus_if.d_data : bus_if.i_data;
            ohit   = dport ? bus_if.d_hit : bus_if.i_hit;
            oerr   = err;
            chk("done_onehot", 32'({bus_if.i_done, bus_if.d_done}), dport ? 32'(2'b01) : 32'(2'b10));
            chk("other_port_quiet", dport ? 32'({bus_if.i_hit, bus_if.i_data}) : 32'({bus_if.d_hit, bus_if.d_data}), 32'd0);
            break;
         end
      end
      bus_if.m_done = 1'b0;
      bus_if.m_err  = 1'b0;
   endtask

   // random-phase model state
   logic        pi, pd, pdw, w, wr, abrt, hv, err_m;
   logic [15:0] pia, pda, pdwd, addr, rdat;
   int          lat, merr, eend;
   int          o_k;
   logic        o_port, o_hit, o_err;
   logic [15:0] o_data;
   logic        tie_exp [3];
`ifdef MEM_ARB_RR_EN
   logic        last_w;
`endif

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      drive_idle();
      reset_dut();
      check_reset_vals("reset");

      // pre_rst ir dr dw ia da dwd lat rdat hit merr | port k data hit err
      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 3,  16'h1234, 1'b1, 0, 1'b0, 4,  16'h1234, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0808, 16'hBEEF, 20, 16'h5A5A, 1'b0, 0, 1'b1, 21, 16'h5A5A, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 5,  16'hCAFE, 1'b0, 0, 1'b1, 6,  16'hCAFE, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1,  16'h0001, 1'b1, 0, 1'b0, 2,  16'h0001, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0777, 16'h0000, TO, 16'h7777, 1'b0, 0, 1'b1, TO+1, 16'h7777, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0999, 16'h0000, TO+1, 16'hFFFF, 1'b1, 0, 1'b1, TO+1, 16'h0000, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0046, 16'h0000, 16'h0000, 3,  16'h2468, 1'b1, 0, 1'b0, 4,  16'h2468, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0044, 16'h0000, 16'h0000, 3,  16'h4321, 1'b1, 2, 1'b0, 4,  16'h4321, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, 16'h1111, 3,  16'h0000, 1'b1, 0, 1'b1, 4,  16'h0000, 1'b1, 1'b1};

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].pre_rst) begin
            reset_dut();
            check_reset_vals("tbl_reset");
         end
         eend = (tbl[i].lat <= TO) ? tbl[i].lat : TO;
         txn(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da, tbl[i].dwd,
             tbl[i].lat, tbl[i].rdat, tbl[i].hit, tbl[i].merr,
             tbl[i].exp_port & tbl[i].dw, tbl[i].exp_port ? tbl[i].da : tbl[i].ia,
             tbl[i].dwd, eend, o_k, o_port, o_data, o_hit, o_err);
         chk($sformatf("tbl%0d_done_cycle", i), 32'(o_k), 32'(tbl[i].exp_k));
         chk($sformatf("tbl%0d_port", i), 32'(o_port), 32'(tbl[i].exp_port));
         chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].exp_data));
         chk($sformatf("tbl%0d_hit", i), 32'(o_hit), 32'(tbl[i].exp_hit));
         chk($sformatf("tbl%0d_err", i), 32'(o_err), 32'(tbl[i].exp_err));
      end

      // err is sticky until reset
      step();
      drive_idle();
      #2;
      chk("err_sticky_idle", 32'(err), 32'(1'b1));
      reset_dut();
      check_reset_vals("err_clear");

      // Tie with both requests held continuously
`ifdef MEM_ARB_RR_EN
      tie_exp[0] = 1'b0; tie_exp[1] = 1'b1; tie_exp[2] = 1'b0;
`else
      tie_exp[0] = 1'b1; tie_exp[1] = 1'b1; tie_exp[2] = 1'b1;
`endif
      for (int t = 0; t < 3; t++) begin
         txn(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0300, 16'h0000, 3, 16'(16'hA000 + t), 1'b1, 0,
             1'b0, tie_exp[t] ? 16'h0300 : 16'h0100, 16'h0000, 3,
             o_k, o_port, o_data, o_hit, o_err);
         chk($sformatf("tie%0d_port", t), 32'(o_port), 32'(tie_exp[t]));
         chk($sformatf("tie%0d_done_cycle", t), 32'(o_k), 32'd4);
         chk($sformatf("tie%0d_data", t), 32'(o_data), 32'(16'hA000 + t));
      end

      // Reset during WAIT drops the transaction
      reset_dut();
      step();
      bus_if.i_req  = 1'b1;
      bus_if.i_addr = 16'h0200;
      step();
      #2;
      chk("rstwait_m_rd_before", 32'(bus_if.m_rd), 32'(1'b1));
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      bus_if.i_req = 1'b0;
      #2;
      chk("rstwait_busy", 32'(busy), 32'(1'b0));
      chk("rstwait_mrdwr", 32'({bus_if.m_rd, bus_if.m_wr}), 32'(2'b00));
      for (int c = 0; c < 4; c++) begin
         step();
         bus_if.m_done = (c == 0);
         #2;
         chk("rstwait_no_done", 32'({bus_if.i_done, bus_if.d_done}), 32'(2'b00));
      end
      bus_if.m_done = 1'b0;

      // Randomized transactions against the reference model
      reset_dut();
      pi = 1'b0;
      pd = 1'b0;
      pdw = 1'b0;
      pia = 16'h0000;
      pda = 16'h0000;
      pdwd = 16'h0000;
      err_m = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_w = 1'b1;
`endif
      for (int n = 0; n < 200; n++) begin
         if (!pi && ($urandom_range(0, 2) != 0)) begin
            pi  = 1'b1;
            pia = 16'($urandom_range(0, 15));
         end
         if (!pd && ($urandom_range(0, 2) != 0)) begin
            pd   = 1'b1;
            pdw  = 1'($urandom);
            pda  = 16'($urandom_range(0, 15));
            pdwd = 16'($urandom);
         end
         if (!pi && !pd) begin
            step();
            drive_idle();
            #2;
            chk("rnd_idle_busy", 32'(busy), 32'(1'b0));
            chk("rnd_idle_err", 32'(err), 32'(err_m));
            continue;
         end
         if (pi && pd) begin
`ifdef MEM_ARB_RR_EN
            w = ~last_w;
`else
            w = 1'b1;
`endif
         end else begin
            w = pd;
         end
         wr   = w & pdw;
         addr = w ? pda : pia;
         lat  = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 3, TO + 4) : $urandom_range(1, 6);
         abrt = (lat > TO);
         eend = abrt ? TO : lat;
         rdat = wr ? 16'($urandom) : mem_rd(addr);
         hv   = 1'($urandom);
         merr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, eend) : 0;
         txn(pi, pd, pdw, pia, pda, pdwd, lat, rdat, hv, merr, wr, addr, pdwd, eend,
             o_k, o_port, o_data, o_hit, o_err);
         err_m = err_m | (merr != 0) | abrt;
         if (!abrt && wr) mem[addr] = pdwd;
         chk("rnd_done_cycle", 32'(o_k), 32'(eend + 1));
         chk("rnd_port", 32'(o_port), 32'(w));
         chk("rnd_data", 32'(o_data), abrt ? 32'd0 : 32'(rdat));
         chk("rnd_hit", 32'(o_hit), abrt ? 32'd0 : 32'(hv));
         chk("rnd_err", 32'(o_err), 32'(err_m));
`ifdef MEM_ARB_RR_EN
         last_w = w;
`endif
         if (w) pd = 1'b0;
         else pi = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
